// File: rtl/udp_rx_probe_tap_if.sv
// UDP receive byte stream as seen by the probe tap: data byte plus valid/last/error qualifiers.
interface udp_rx_probe_tap_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_last;
   logic       rx_err;

   modport master (output rx_data, rx_valid, rx_last, rx_err);
   modport slave  (input  rx_data, rx_valid, rx_last, rx_err);
endinterface

// File: rtl/udp_rx_probe_tap.sv
// Passive tap on the UDP receive stream: frame-state tracking plus registered probe buses
// for the downstream logic analyzer. Every probe is exactly one cycle behind the stream.
module udp_rx_probe_tap #(
   parameter int TS_W    = 25,
   parameter int FCNT_W  = 25,
   parameter int MAX_LEN = 1480
) (
   input  logic              clk,
   input  logic              rst,
   udp_rx_probe_tap_if.slave rx_if,
   input  logic              cnt_clr_i,
   output logic [7:0]        probe_data_o,
   output logic              probe_valid_o,
   output logic [15:0]       probe_byte_idx_o,
   output logic [TS_W-1:0]   probe_ts_o,
   output logic [1:0]        probe_state_o,
   output logic [7:0]        probe_err_cnt_o,
   output logic [FCNT_W-1:0] probe_frame_cnt_o,
   output logic [3:0]        probe_flags_o,
   output logic              probe_sof_o,
   output logic              probe_eof_o,
   output logic [15:0]       probe_udp_len_o
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_HDR = 2'd1, S_PAYLOAD = 2'd2, S_DROP = 2'd3} state_t;

   localparam logic [15:0] LAST_IDX = 16'(MAX_LEN - 1);
   localparam int F_LEN = 3, F_RXERR = 2, F_RUNT = 1, F_OVF = 0;

   logic [1:0]        rst_sync_q;
   logic              rst_int;
   state_t            state_q, state_d;
   logic [15:0]       idx_q, cur_idx, byte_idx_q;
   logic [7:0]        data_q, len_hi_q, err_cnt_q;
   logic              valid_q, sof_q, sof_d, eof_q, eof_d, len_bad;
   logic [3:0]        flags_q, flags_d, set_flags;
   logic [15:0]       udp_len_q;
   logic [TS_W-1:0]   ts_q;
   logic [FCNT_W-1:0] frame_cnt_q;

   wire v = rx_if.rx_valid;
   wire l = rx_if.rx_last;
   wire e = rx_if.rx_err;

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rst_sync_q <= 2'b11;
      else     rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_int = rst_sync_q[1];

   assign cur_idx = (state_q == S_IDLE) ? 16'd0 : idx_q;
   assign len_bad = (cur_idx + 16'd1) != udp_len_q;

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) state_q <= S_DROP;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:
            if (v) begin
               if (l)      state_d = S_IDLE;
               else if (e) state_d = S_DROP;
               else        state_d = S_HDR;
            end
         S_HDR:
            if (!v || l)               state_d = S_IDLE;
            else if (e)                state_d = S_DROP;
            else if (cur_idx == 16'd7) state_d = S_PAYLOAD;
         S_PAYLOAD:
            if (!v || l)                         state_d = S_IDLE;
            else if (e || cur_idx == LAST_IDX)   state_d = S_DROP;
         default:
            if (!v || l) state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sof_d     = 1'b0;
      eof_d     = 1'b0;
      set_flags = 4'b0000;
      case (state_q)
         S_IDLE:
            if (v) begin
               sof_d = 1'b1;
               if (l) begin
                  eof_d = 1'b1;
                  set_flags[F_RUNT] = 1'b1;
               end
               if (e) begin
                  eof_d = 1'b1;
                  set_flags[F_RXERR] = 1'b1;
               end
            end
         S_HDR:
            if (!v) begin
               eof_d = 1'b1;
               set_flags[F_RUNT] = 1'b1;
            end else begin
               if (e) begin
                  eof_d = 1'b1;
                  set_flags[F_RXERR] = 1'b1;
               end
               if (l) begin
                  eof_d = 1'b1;
                  if (cur_idx < 16'd7) set_flags[F_RUNT] = 1'b1;
                  else if (len_bad)    set_flags[F_LEN]  = 1'b1;
               end
            end
         S_PAYLOAD:
            if (!v) begin
               eof_d = 1'b1;
               set_flags[F_LEN] = 1'b1;
            end else begin
               if (e) begin
                  eof_d = 1'b1;
                  set_flags[F_RXERR] = 1'b1;
               end
               if (l) begin
                  eof_d = 1'b1;
                  set_flags[F_LEN] = len_bad;
               end else if (cur_idx == LAST_IDX) begin
                  eof_d = 1'b1;
                  set_flags[F_OVF] = 1'b1;
               end
            end
         default: ;
      endcase
   end

   assign flags_d = sof_d ? set_flags : (flags_q | set_flags);

   always_ff @(posedge clk or posedge rst_int) begin
      if (rst_int) begin
         data_q      <= '0;
         valid_q     <= 1'b0;
         idx_q       <= '0;
         byte_idx_q  <= '0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         flags_q     <= '0;
         len_hi_q    <= '0;
         udp_len_q   <= '0;
         ts_q        <= '0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         data_q  <= rx_if.rx_data;
         valid_q <= v;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         flags_q <= flags_d;
         if (v) begin
            idx_q      <= cur_idx + 16'd1;
            byte_idx_q <= cur_idx;
         end
         // Length is published whole on byte 5 so the previous value holds through byte 4.
         if (state_q == S_HDR && v && cur_idx == 16'd4) len_hi_q  <= rx_if.rx_data;
         if (state_q == S_HDR && v && cur_idx == 16'd5) udp_len_q <= {len_hi_q, rx_if.rx_data};
         if (cnt_clr_i) ts_q <= '0;
         else           ts_q <= ts_q + TS_W'(1);
         if (cnt_clr_i) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
         end else if (eof_d) begin
            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            if (|flags_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign probe_data_o      = data_q;
   assign probe_valid_o     = valid_q;
   assign probe_byte_idx_o  = byte_idx_q;
   assign probe_ts_o        = ts_q;
   assign probe_state_o     = state_q;
   assign probe_err_cnt_o   = err_cnt_q;
   assign probe_frame_cnt_o = frame_cnt_q;
   assign probe_flags_o     = flags_q;
   assign probe_sof_o       = sof_q;
   assign probe_eof_o       = eof_q;
   assign probe_udp_len_o   = udp_len_q;
endmodule

// File: tb/tb_udp_rx_probe_tap.sv
// Directed bench for udp_rx_probe_tap: normal, length-error, runt, rx_err, overflow, reset and saturation cases.
module tb_udp_rx_probe_tap;
   logic        clk = 1'b0;
   logic        rst;
   logic        cnt_clr;
   logic [7:0]  probe_data;
   logic        probe_valid;
   logic [15:0] probe_byte_idx;
   logic [24:0] probe_ts;
   logic [1:0]  probe_state;
   logic [7:0]  probe_err_cnt;
   logic [24:0] probe_frame_cnt;
   logic [3:0]  probe_flags;
   logic        probe_sof;
   logic        probe_eof;
   logic [15:0] probe_udp_len;

   int total = 0;
   int bad   = 0;

   int sof_n, eof_n, sof_idx, eof_idx;
   logic [3:0]  eof_flags;
   logic [1:0]  st_at   [0:2047];
   logic [15:0] ulen_at [0:2047];
   logic [7:0]  dat_at  [0:2047];
   int          ts_at   [0:2047];

   udp_rx_probe_tap_if rx_if ();

   udp_rx_probe_tap dut (
      .clk               (clk),
      .rst               (rst),
      .rx_if             (rx_if),
      .cnt_clr_i         (cnt_clr),
      .probe_data_o      (probe_data),
      .probe_valid_o     (probe_valid),
      .probe_byte_idx_o  (probe_byte_idx),
      .probe_ts_o        (probe_ts),
      .probe_state_o     (probe_state),
      .probe_err_cnt_o   (probe_err_cnt),
      .probe_frame_cnt_o (probe_frame_cnt),
      .probe_flags_o     (probe_flags),
      .probe_sof_o       (probe_sof),
      .probe_eof_o       (probe_eof),
      .probe_udp_len_o   (probe_udp_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stream input; probes for that cycle are valid on return.
   task automatic step(input logic [7:0] d, input logic v, input logic l, input logic e);
      rx_if.rx_data  = d;
      rx_if.rx_valid = v;
      rx_if.rx_last  = l;
      rx_if.rx_err   = e;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rec();
      sof_n = 0; eof_n = 0; sof_idx = -1; eof_idx = -1; eof_flags = 4'hx;
   endtask

   task automatic rec(input int i);
      if (probe_sof) begin sof_n++; sof_idx = int'(probe_byte_idx); end
      if (probe_eof) begin eof_n++; eof_idx = int'(probe_byte_idx); eof_flags = probe_flags; end
      st_at[i]   = probe_state;
      ulen_at[i] = probe_udp_len;
      dat_at[i]  = probe_data;
      ts_at[i]   = int'(probe_ts);
   endtask

   // n valid bytes (bytes 4/5 carry ulen), last/err at given index (-1 = never), then one idle cycle.
   task automatic send_frame(input int n, input logic [15:0] ulen, input int last_at, input int err_at);
      logic [7:0] d;
      clear_rec();
      for (int i = 0; i < n; i++) begin
         d = (i == 4) ? ulen[15:8] : (i == 5) ? ulen[7:0] : 8'(i);
         step(d, 1'b1, i == last_at, i == err_at);
         rec(i);
      end
      step(8'h00, 1'b0, 1'b0, 1'b0);
      rec(n);
   endtask

   task automatic clr_counters();
      cnt_clr = 1'b1;
      step(8'h00, 1'b0, 1'b0, 1'b0);
      cnt_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cnt_clr = 1'b0;
      rx_if.rx_data = 8'h00; rx_if.rx_valid = 1'b0; rx_if.rx_last = 1'b0; rx_if.rx_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", probe_state, 2'd3);
      chk("rst_data", probe_data, 8'h00);
      chk("rst_valid", probe_valid, 1'b0);
      chk("rst_ts", probe_ts, 25'd0);
      chk("rst_fcnt", probe_frame_cnt, 25'd0);
      chk("rst_flags", probe_flags, 4'h0);
      rst = 1'b0;
      repeat (4) step(8'h00, 1'b0, 1'b0, 1'b0);
      chk("idle_after_rst", probe_state, 2'd0);

      clr_counters();
      chk("clr_ts0", probe_ts, 25'd0);
      step(8'h00, 1'b0, 1'b0, 1'b0);
      chk("ts_inc", probe_ts, 25'd1);

      // 1: good 20-byte datagram
      send_frame(20, 16'h0014, 19, -1);
      chk("t1_sof_idx", sof_idx, 0);
      chk("t1_eof_idx", eof_idx, 19);
      chk("t1_eof_n", eof_n, 1);
      chk("t1_flags", eof_flags, 4'b0000);
      chk("t1_fcnt", probe_frame_cnt, 25'd1);
      chk("t1_ecnt", probe_err_cnt, 8'd0);
      chk("t1_ulen", probe_udp_len, 16'h0014);
      chk("t1_data10", dat_at[10], 8'h0A);
      chk("t1_ts_step", ts_at[11] - ts_at[10], 1);
      chk("t1_state_hdr", st_at[3], 2'd1);
      chk("t1_state_pay", st_at[10], 2'd2);

      // 2: length mismatch
      clr_counters();
      send_frame(20, 16'h0020, 19, -1);
      chk("t2_flags", eof_flags, 4'b1000);
      chk("t2_ecnt", probe_err_cnt, 8'd1);
      chk("t2_fcnt", probe_frame_cnt, 25'd1);

      // 3: runt
      clr_counters();
      send_frame(4, 16'h0004, 3, -1);
      chk("t3_flags", eof_flags, 4'b0010);
      chk("t3_eof_idx", eof_idx, 3);
      chk("t3_state", st_at[3], 2'd0);
      chk("t3_ecnt", probe_err_cnt, 8'd1);

      // 4: rx_err mid payload
      clr_counters();
      send_frame(30, 16'h001E, 29, 10);
      chk("t4_flags", eof_flags, 4'b0100);
      chk("t4_eof_idx", eof_idx, 10);
      chk("t4_eof_n", eof_n, 1);
      chk("t4_drop20", st_at[20], 2'd3);
      chk("t4_drop28", st_at[28], 2'd3);
      chk("t4_fcnt", probe_frame_cnt, 25'd1);

      // 5: overflow, then a normal frame
      clr_counters();
      send_frame(1500, 16'h05DC, -1, -1);
      chk("t5_flags", eof_flags, 4'b0001);
      chk("t5_eof_idx", eof_idx, 1479);
      chk("t5_eof_n", eof_n, 1);
      chk("t5_drop", st_at[1479], 2'd3);
      chk("t5_fcnt", probe_frame_cnt, 25'd1);
      send_frame(20, 16'h0014, 19, -1);
      chk("t5b_sof_idx", sof_idx, 0);
      chk("t5b_flags", eof_flags, 4'b0000);
      chk("t5b_fcnt", probe_frame_cnt, 25'd2);
      chk("t5b_ecnt", probe_err_cnt, 8'd1);
      chk("t5b_ulen_hold", ulen_at[4], 16'h05DC);
      chk("t5b_ulen_new", ulen_at[5], 16'h0014);

      // clear coincident with eof
      cnt_clr = 1'b1;
      step(8'h11, 1'b1, 1'b1, 1'b0);
      cnt_clr = 1'b0;
      chk("clr_eof_pulse", probe_eof, 1'b1);
      chk("clr_eof_fcnt", probe_frame_cnt, 25'd0);
      chk("clr_eof_ecnt", probe_err_cnt, 8'd0);
      step(8'h00, 1'b0, 1'b0, 1'b0);

      // 6: reset mid-frame
      clear_rec();
      for (int i = 0; i < 13; i++) step(8'(i + 8'h40), 1'b1, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_state", probe_state, 2'd3);
      chk("t6_data", probe_data, 8'h00);
      chk("t6_valid", probe_valid, 1'b0);
      chk("t6_idx", probe_byte_idx, 16'd0);
      chk("t6_ulen", probe_udp_len, 16'd0);
      @(posedge clk);
      #1;
      for (int i = 14; i < 26; i++) begin
         if (i == 16) rst = 1'b0;
         step(8'(i + 8'h40), 1'b1, i == 25, 1'b0);
         rec(i);
      end
      step(8'h00, 1'b0, 1'b0, 1'b0);
      chk("t6_tail_sof", sof_n, 0);
      chk("t6_tail_eof", eof_n, 0);
      chk("t6_tail_state", st_at[20], 2'd3);
      chk("t6_fcnt", probe_frame_cnt, 25'd0);
      send_frame(20, 16'h0014, 19, -1);
      chk("t6_next_sof_n", sof_n, 1);
      chk("t6_next_sof_idx", sof_idx, 0);
      chk("t6_next_flags", eof_flags, 4'b0000);
      chk("t6_next_fcnt", probe_frame_cnt, 25'd1);
      for (int i = 0; i < 300; i++) begin
         step(8'h00, 1'b1, 1'b1, 1'b0);
         step(8'h00, 1'b0, 1'b0, 1'b0);
      end
      chk("t6_ecnt_sat", probe_err_cnt, 8'd255);
      chk("t6_fcnt_301", probe_frame_cnt, 25'd301);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
